// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: states, mux selects,
// opcodes, ALU operation classes and ALU control codes.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECR    = 4'd7,
    S_EXECI    = 4'd8,
    S_ALUWB    = 4'd9,
    S_BRANCH   = 4'd10,
    S_JAL      = 4'd11,
    S_JALR     = 4'd12,
    S_JALRLINK = 4'd13,
    S_LUI      = 4'd14,
    S_AUIPC    = 4'd15
  } state_t;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RD1   = 2'b10,
    SRCA_ZERO  = 2'b11
  } src_a_t;

  typedef enum logic [1:0] {
    SRCB_RD2   = 2'b00,
    SRCB_IMM   = 2'b01,
    SRCB_FOUR  = 2'b10,
    SRCB_NONE  = 2'b11
  } src_b_t;

  typedef enum logic [1:0] {
    RES_ALUOUT = 2'b00,
    RES_DATA   = 2'b01,
    RES_ALURES = 2'b10
  } result_src_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  // State-driven control word; write enables are gated by reset at the top.
  typedef struct packed {
    logic        pc_write;
    logic        adr_src;
    logic        mem_write;
    logic        ir_write;
    result_src_t result_src;
    src_a_t      alu_src_a;
    src_b_t      alu_src_b;
    logic        reg_write;
    alu_op_t     alu_op;
    logic        illegal;
  } ctrl_t;

  function automatic logic [2:0] imm_decode(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_IMM, OP_JALR: imm_decode = IMM_I;
      OP_STORE:                 imm_decode = IMM_S;
      OP_BRANCH:                imm_decode = IMM_B;
      OP_JAL:                   imm_decode = IMM_J;
      OP_LUI, OP_AUIPC:         imm_decode = IMM_U;
      default:                  imm_decode = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: maps the FSM's ALU operation class plus the
// instruction funct fields to a 4-bit ALU control code.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  alu_op_t     i_alu_op,
  input  logic [2:0]  i_funct3,
  input  logic        i_funct7b5,
  input  logic        i_op5,
  output logic [3:0]  o_alu_control
);

  logic w_sub;

  // I-type immediates can set bit 30, so only R-type (op[5]=1) may select SUB.
  assign w_sub = i_op5 & i_funct7b5;

  always_comb begin
    o_alu_control = ALU_ADD;
    case (i_alu_op)
      ALUOP_ADD: o_alu_control = ALU_ADD;
      ALUOP_SUB: o_alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct3)
          3'b000:  o_alu_control = w_sub ? ALU_SUB : ALU_ADD;
          3'b001:  o_alu_control = ALU_SLL;
          3'b010:  o_alu_control = ALU_SLT;
          3'b011:  o_alu_control = ALU_SLTU;
          3'b100:  o_alu_control = ALU_XOR;
          3'b101:  o_alu_control = i_funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  o_alu_control = ALU_OR;
          default: o_alu_control = ALU_AND;
        endcase
      end
      default: o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I main control: Moore FSM driving datapath selects and
// enables, with an ALU decoder for the funct-dependent operations.
module multicycle_control_fsm
  import riscv_ctrl_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [6:0]  i_op,
  input  logic [2:0]  i_funct3,
  input  logic        i_funct7b5,
  input  logic        i_zero,
  output logic        o_pc_write,
  output logic        o_adr_src,
  output logic        o_mem_write,
  output logic        o_ir_write,
  output logic [1:0]  o_result_src,
  output logic [1:0]  o_alu_src_a,
  output logic [1:0]  o_alu_src_b,
  output logic        o_reg_write,
  output logic [2:0]  o_imm_src,
  output logic [3:0]  o_alu_control,
  output logic        o_illegal_instr,
  output logic [3:0]  o_state_dbg
);

  state_t r_state;
  state_t w_next;
  ctrl_t  w_ctrl;
  logic   w_br_taken;
  logic   w_br_legal;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_RESET;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_RESET:  w_next = S_FETCH;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (i_op)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_R:              w_next = S_EXECR;
          OP_IMM:            w_next = S_EXECI;
          OP_BRANCH:         w_next = S_BRANCH;
          OP_JAL:            w_next = S_JAL;
          OP_JALR:           w_next = S_JALR;
          OP_LUI:            w_next = S_LUI;
          OP_AUIPC:          w_next = S_AUIPC;
          default:           w_next = S_FETCH;
        endcase
      end
      S_MEMADR:   w_next = i_op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  w_next = S_MEMWB;
      S_EXECR,
      S_EXECI,
      S_JAL,
      S_LUI,
      S_AUIPC:    w_next = S_ALUWB;
      S_JALR:     w_next = S_JALRLINK;
      default:    w_next = S_FETCH;
    endcase
  end

  // Only beq/bne are supported; other funct3 values never redirect the PC.
  assign w_br_legal = (i_funct3[2:1] == 2'b00);
  assign w_br_taken = ((i_funct3 == 3'b000) &  i_zero) |
                      ((i_funct3 == 3'b001) & ~i_zero);

  always_comb begin
    w_ctrl = '0;
    case (r_state)
      S_FETCH: begin
        w_ctrl.ir_write   = 1'b1;
        w_ctrl.pc_write   = 1'b1;
        w_ctrl.alu_src_a  = SRCA_PC;
        w_ctrl.alu_src_b  = SRCB_FOUR;
        w_ctrl.result_src = RES_ALURES;
      end
      S_DECODE: begin
        w_ctrl.alu_src_a = SRCA_OLDPC;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.illegal   = ~(i_op inside {OP_LOAD, OP_STORE, OP_R, OP_IMM, OP_BRANCH,
                                          OP_JAL, OP_JALR, OP_LUI, OP_AUIPC});
      end
      S_MEMADR: begin
        w_ctrl.alu_src_a = SRCA_RD1;
        w_ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        w_ctrl.adr_src    = 1'b1;
        w_ctrl.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        w_ctrl.result_src = RES_DATA;
        w_ctrl.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        w_ctrl.adr_src   = 1'b1;
        w_ctrl.mem_write = 1'b1;
      end
      S_EXECR: begin
        w_ctrl.alu_src_a = SRCA_RD1;
        w_ctrl.alu_src_b = SRCB_RD2;
        w_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        w_ctrl.alu_src_a = SRCA_RD1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        w_ctrl.result_src = RES_ALUOUT;
        w_ctrl.reg_write  = 1'b1;
      end
      S_BRANCH: begin
        w_ctrl.alu_src_a  = SRCA_RD1;
        w_ctrl.alu_src_b  = SRCB_RD2;
        w_ctrl.alu_op     = ALUOP_SUB;
        w_ctrl.result_src = RES_ALUOUT;
        w_ctrl.pc_write   = w_br_taken;
        w_ctrl.illegal    = ~w_br_legal;
      end
      S_JAL: begin
        w_ctrl.alu_src_a  = SRCA_OLDPC;
        w_ctrl.alu_src_b  = SRCB_FOUR;
        w_ctrl.result_src = RES_ALUOUT;
        w_ctrl.pc_write   = 1'b1;
      end
      S_JALR: begin
        w_ctrl.alu_src_a  = SRCA_RD1;
        w_ctrl.alu_src_b  = SRCB_IMM;
        w_ctrl.result_src = RES_ALURES;
        w_ctrl.pc_write   = 1'b1;
      end
      // Link written after the PC update so rd==rs1 cannot corrupt the target.
      S_JALRLINK: begin
        w_ctrl.alu_src_a  = SRCA_OLDPC;
        w_ctrl.alu_src_b  = SRCB_FOUR;
        w_ctrl.result_src = RES_ALURES;
        w_ctrl.reg_write  = 1'b1;
      end
      S_LUI: begin
        w_ctrl.alu_src_a = SRCA_ZERO;
        w_ctrl.alu_src_b = SRCB_IMM;
      end
      S_AUIPC: begin
        w_ctrl.alu_src_a = SRCA_OLDPC;
        w_ctrl.alu_src_b = SRCB_IMM;
      end
      default: w_ctrl = '0;
    endcase
  end

  alu_decoder u_alu_dec (
    .i_alu_op      (w_ctrl.alu_op),
    .i_funct3      (i_funct3),
    .i_funct7b5    (i_funct7b5),
    .i_op5         (i_op[5]),
    .o_alu_control (o_alu_control)
  );

  assign o_pc_write      = w_ctrl.pc_write  & ~i_reset;
  assign o_ir_write      = w_ctrl.ir_write  & ~i_reset;
  assign o_reg_write     = w_ctrl.reg_write & ~i_reset;
  assign o_mem_write     = w_ctrl.mem_write & ~i_reset;
  assign o_adr_src       = w_ctrl.adr_src;
  assign o_result_src    = w_ctrl.result_src;
  assign o_alu_src_a     = w_ctrl.alu_src_a;
  assign o_alu_src_b     = w_ctrl.alu_src_b;
  assign o_illegal_instr = w_ctrl.illegal;
  assign o_imm_src       = (r_state == S_RESET) ? 3'b000 : imm_decode(i_op);
  assign o_state_dbg     = r_state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks each instruction class
// through its state sequence and checks every output against hand values.
module tb_multicycle_control_fsm;
  import riscv_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_src;
  logic [3:0] alu_control, state_dbg;

  int n_assert = 0;
  int n_fail   = 0;

  multicycle_control_fsm dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_op            (op),
    .i_funct3        (funct3),
    .i_funct7b5      (funct7b5),
    .i_zero          (zero),
    .o_pc_write      (pc_write),
    .o_adr_src       (adr_src),
    .o_mem_write     (mem_write),
    .o_ir_write      (ir_write),
    .o_result_src    (result_src),
    .o_alu_src_a     (alu_src_a),
    .o_alu_src_b     (alu_src_b),
    .o_reg_write     (reg_write),
    .o_imm_src       (imm_src),
    .o_alu_control   (alu_control),
    .o_illegal_instr (illegal_instr),
    .o_state_dbg     (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic z);
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    #1;
  endtask

  // Vector order: state, pc_w, adr, mem_w, ir_w, res, a, b, reg_w, imm, aluc, illegal
  task automatic chk(input string tag, input logic [3:0] st, input logic pcw,
                     input logic adr, input logic memw, input logic irw,
                     input logic [1:0] res, input logic [1:0] a, input logic [1:0] b,
                     input logic regw, input logic [2:0] imm, input logic [3:0] aluc,
                     input logic ill);
    logic [22:0] obs, exp;
    exp = {st, pcw, adr, memw, irw, res, a, b, regw, imm, aluc, ill};
    obs = {state_dbg, pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, reg_write, imm_src, alu_control, illegal_instr};
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_fetch(input string tag, input logic [2:0] imm);
    chk(tag, S_FETCH, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 0, imm, 4'b0000, 0);
  endtask

  task automatic chk_decode(input string tag, input logic [2:0] imm, input logic ill);
    chk(tag, S_DECODE, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, imm, 4'b0000, ill);
  endtask

  task automatic chk_aluwb(input string tag, input logic [2:0] imm);
    chk(tag, S_ALUWB, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, imm, 4'b0000, 0);
  endtask

  // Runs a branch from FETCH back to FETCH, checking BRANCH outputs.
  task automatic run_branch(input string tag, input logic [2:0] f3, input logic z,
                            input logic exp_pcw, input logic exp_ill);
    set_instr(7'b1100011, f3, 1'b0, z);
    chk_fetch({tag, "_f"}, 3'b010);
    tick(); chk_decode({tag, "_d"}, 3'b010, 0);
    tick(); chk({tag, "_br"}, S_BRANCH, exp_pcw, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 3'b010,
                4'b0001, exp_ill);
    tick();
  endtask

  // R/I-type from FETCH: checks the EXEC state's select and ALU code, then ALUWB.
  task automatic run_alu(input string tag, input logic [6:0] o, input logic [2:0] f3,
                         input logic f7, input logic [3:0] st, input logic [1:0] b,
                         input logic [3:0] aluc);
    set_instr(o, f3, f7, 1'b0);
    tick(); tick();
    chk({tag, "_ex"}, st, 0, 0, 0, 0, 2'b00, 2'b10, b, 0, 3'b000, aluc, 0);
    tick(); tick();
  endtask

  initial begin
    reset = 1'b1;
    set_instr(7'b0, 3'b0, 1'b0, 1'b0);
    tick(); tick();
    chk("rst_held", S_RESET, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 4'b0000, 0);
    reset = 1'b0; #1;
    chk("rst_rel", S_RESET, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 4'b0000, 0);
    tick();
    chk_fetch("fetch0", 3'b000);

    // addi x1,x0,5 (0x00500093)
    set_instr(7'b0010011, 3'b000, 1'b0, 1'b0);
    chk_fetch("addi_f", 3'b000);
    tick(); chk_decode("addi_d", 3'b000, 0);
    tick(); chk("addi_ex", S_EXECI, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 3'b000, 4'b0000, 0);
    tick(); chk_aluwb("addi_wb", 3'b000);
    tick(); chk_fetch("addi_next", 3'b000);

    // lw: 5 cycles
    set_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
    tick(); chk_decode("lw_d", 3'b000, 0);
    tick(); chk("lw_adr", S_MEMADR, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 3'b000, 4'b0000, 0);
    tick(); chk("lw_rd", S_MEMREAD, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 4'b0000, 0);
    tick(); chk("lw_wb", S_MEMWB, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 1, 3'b000, 4'b0000, 0);
    tick(); chk_fetch("lw_next", 3'b000);

    // sw: 4 cycles, mem_write only in cycle 4
    set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
    chk_fetch("sw_f", 3'b001);
    tick(); chk_decode("sw_d", 3'b001, 0);
    tick(); chk("sw_adr", S_MEMADR, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 3'b001, 4'b0000, 0);
    tick(); chk("sw_wr", S_MEMWRITE, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 3'b001, 4'b0000, 0);
    tick(); chk_fetch("sw_next", 3'b001);

    run_branch("beq_z1", 3'b000, 1'b1, 1'b1, 1'b0);
    run_branch("beq_z0", 3'b000, 1'b0, 1'b0, 1'b0);
    run_branch("bne_z1", 3'b001, 1'b1, 1'b0, 1'b0);
    run_branch("bne_z0", 3'b001, 1'b0, 1'b1, 1'b0);
    run_branch("blt_ill", 3'b100, 1'b1, 1'b0, 1'b1);
    chk_fetch("br_next", 3'b010);

    // SUB only for R-type; SRA for both R and I with bit 30 set
    run_alu("sub",   7'b0110011, 3'b000, 1'b1, S_EXECR, 2'b00, 4'b0001);
    run_alu("add_r", 7'b0110011, 3'b000, 1'b0, S_EXECR, 2'b00, 4'b0000);
    run_alu("addi_neg", 7'b0010011, 3'b000, 1'b1, S_EXECI, 2'b01, 4'b0000);
    run_alu("sra",   7'b0110011, 3'b101, 1'b1, S_EXECR, 2'b00, 4'b1001);
    run_alu("srli",  7'b0010011, 3'b101, 1'b0, S_EXECI, 2'b01, 4'b1000);
    run_alu("and",   7'b0110011, 3'b111, 1'b0, S_EXECR, 2'b00, 4'b0010);
    run_alu("sltu",  7'b0110011, 3'b011, 1'b0, S_EXECR, 2'b00, 4'b0110);

    // Illegal opcode: 2 cycles, pulse only in DECODE
    set_instr(7'b0000000, 3'b000, 1'b0, 1'b0);
    chk_fetch("ill_f", 3'b000);
    tick(); chk_decode("ill_d", 3'b000, 1);
    tick(); chk_fetch("ill_next", 3'b000);

    // lui x1,0x12345 (0x123450B7)
    set_instr(7'b0110111, 3'b000, 1'b0, 1'b0);
    tick(); chk_decode("lui_d", 3'b100, 0);
    tick(); chk("lui_ex", S_LUI, 0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 0, 3'b100, 4'b0000, 0);
    tick(); chk_aluwb("lui_wb", 3'b100);
    tick();

    set_instr(7'b0010111, 3'b000, 1'b0, 1'b0);
    tick(); tick();
    chk("auipc_ex", S_AUIPC, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, 3'b100, 4'b0000, 0);
    tick(); chk_aluwb("auipc_wb", 3'b100);
    tick();

    set_instr(7'b1100111, 3'b000, 1'b0, 1'b0);
    tick(); tick();
    chk("jalr_pc", S_JALR, 1, 0, 0, 0, 2'b10, 2'b10, 2'b01, 0, 3'b000, 4'b0000, 0);
    tick(); chk("jalr_link", S_JALRLINK, 0, 0, 0, 0, 2'b10, 2'b01, 2'b10, 1, 3'b000,
                4'b0000, 0);
    tick(); chk_fetch("jalr_next", 3'b000);

    set_instr(7'b1101111, 3'b000, 1'b0, 1'b0);
    tick(); tick();
    chk("jal_pc", S_JAL, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 0, 3'b011, 4'b0000, 0);
    tick(); chk_aluwb("jal_wb", 3'b011);
    tick();

    // Reset arriving in MEMWRITE must suppress the store
    set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
    tick(); tick(); tick();
    reset = 1'b1; #1;
    chk("rst_sw", S_MEMWRITE, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'b001, 4'b0000, 0);
    tick();
    chk("rst_sw_st", S_RESET, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 4'b0000, 0);
    reset = 1'b0; #1;
    tick(); chk_fetch("rst_sw_f", 3'b001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Main control unit of the multicycle RV32I core. It is a Moore state machine plus an ALU decoder. It generates the 2-bit ALUSrcA/ALUSrcB selects that drive the SrcA/SrcB 4:1 datapath muxes. It also drives all datapath write enables, result/address selects, the immediate format and the ALU operation. Sits between the instruction register (op/funct fields) and the datapath.

Parameters:
None. Encodings are fixed in the shared package.

Ports:
clk  in  1  core clock, rising edge
reset  in  1  synchronous, active-high reset
op  in  7  instruction opcode, instr[6:0]
funct3  in  3  instr[14:12]
funct7b5  in  1  instr[30]
zero  in  1  ALU zero flag, same cycle
pc_write  out  1  PC register enable
adr_src  out  1  memory address: 0 = PC, 1 = ALUOut
mem_write  out  1  data memory write enable
ir_write  out  1  instruction register and OldPC enable
result_src  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = RD1 (A register), 11 = zero
alu_src_b  out  2  00 = RD2 (WriteData), 01 = ImmExt, 10 = constant 4, 11 = unused
reg_write  out  1  register file write enable
imm_src  out  3  000 = I, 001 = S, 010 = B, 011 = J, 100 = U
alu_control  out  4  ALU operation
illegal_instr  out  1  one-cycle pulse on an unsupported opcode or funct3
state_dbg  out  4  current state encoding

Behaviour:
- State register updates on rising clk. All outputs are combinational from the state. Exceptions: pc_write in BRANCH, and imm_src/alu_control, which also decode the instruction fields.
- Reset sets state to S_RESET.
  - In S_RESET all outputs are 0.
  - S_RESET -> S_FETCH unconditionally.
- While reset = 1, pc_write, ir_write, reg_write and mem_write are forced to 0 in every state. This suppresses a write that would otherwise land on the reset edge.
- Unlisted outputs in each state are 0. "add" means alu_op = ADD.
- FETCH: adr_src=0, ir_write=1, a=00, b=10, add, result_src=10, pc_write=1 -> DECODE.
- DECODE: a=01, b=01, add (ALUOut = branch/JAL target). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - 0010111 -> AUIPC
  - any other op -> FETCH, with illegal_instr=1 during DECODE
- MEMADR: a=10, b=01, add -> MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD: adr_src=1, result_src=00 -> MEMWB.
- MEMWB: result_src=01, reg_write=1 -> FETCH.
- MEMWRITE: adr_src=1, mem_write=1 -> FETCH.
- EXECR: a=10, b=00, alu_op=FUNCT -> ALUWB.
- EXECI: a=10, b=01, alu_op=FUNCT -> ALUWB.
- ALUWB: result_src=00, reg_write=1 -> FETCH.
- BRANCH: a=10, b=00, SUB, result_src=00.
  - pc_write = (funct3==000 & zero) | (funct3==001 & ~zero).
  - Any other funct3: pc_write=0 and illegal_instr=1.
  - -> FETCH.
- JAL: a=01, b=10, add, result_src=00, pc_write=1 -> ALUWB.
- JALR: a=10, b=01, add, result_src=10, pc_write=1 -> JALRLINK.
- JALRLINK: a=01, b=10, add, result_src=10, reg_write=1 -> FETCH. PC is updated before rd, so rd==rs1 is safe.
- LUI: a=11, b=01, add -> ALUWB.
- AUIPC: a=01, b=01, add -> ALUWB.
- imm_src decodes from op in every state: I for load/OP-IMM/JALR, S for store, B for branch, J for JAL, U for LUI/AUIPC, 000 otherwise.
- Latencies in cycles, counted from FETCH:
  - lw 5; sw 4
  - R/I/LUI/AUIPC 4
  - branch 3; jal 4; jalr 4
  - illegal 2

Decomposition:
- Package riscv_ctrl_pkg holds:
  - state enum (4-bit)
  - ALUSrcA, ALUSrcB, ResultSrc and ImmSrc encodings
  - opcode constants
  - alu_op (00 ADD, 01 SUB, 10 FUNCT)
  - alu_control codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001
- Sub-module alu_decoder is purely combinational. Inputs: alu_op, funct3, funct7b5, op[5]. Output: alu_control.
  - SUB only when op[5]=1 & funct7b5=1 & funct3=000.
  - SRA when funct3=101 & funct7b5=1 (R or I).

Test Plan:
- Reset held 2 cycles, then released -> all outputs 0 in S_RESET; next cycle FETCH with ir_write=1, pc_write=1, a=00, b=10.
- addi x1,x0,5 (0x00500093) -> states FETCH, DECODE, EXECI, ALUWB; reg_write=1 only in cycle 4; alu_control=0000; imm_src=000.
- lw (op 0000011) -> 5 cycles; adr_src=1 in MEMREAD; result_src=01 and reg_write=1 in MEMWB; sw (op 0100011) -> mem_write=1 exactly once, in cycle 4.
- beq (funct3 000): zero=1 -> pc_write=1 in BRANCH; zero=0 -> pc_write=0. bne (funct3 001) with zero=1 -> pc_write=0. R-type sub (funct7b5=1) -> alu_control=0001.
- op=0000000 -> illegal_instr=1 for one cycle in DECODE, then back to FETCH. lui (0x123450B7) -> a=11, b=01, imm_src=100; jalr -> pc_write in JALR, reg_write in JALRLINK.
- reset asserted during MEMWRITE -> mem_write=0 that cycle; state S_RESET next, then FETCH.
